// File: rtl/parity_gen_chk.sv
// Parameterised parity generator (one-stage valid/ready pipeline) and
// always-accepting parity checker with error pulse, sticky flag and saturating counters.
module parity_gen_chk #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd,
  input  logic             gen_valid,
  output logic             gen_ready,
  input  logic [WIDTH-1:0] gen_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             chk_par,
  input  logic             clr,
  output logic             chk_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e             slot_q;
  logic [WIDTH-1:0]  data_q;
  logic              par_q;

  logic              gen_par;
  logic              gen_accept;

  logic              chk_fail;
  logic              chk_err_q, chk_err_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Generator path

  assign gen_par    = (^gen_data) ^ odd;
  assign gen_ready  = (slot_q == SLOT_EMPTY) || out_ready;
  assign gen_accept = gen_valid && gen_ready;

  // A load takes priority over a drain, so a simultaneous drain+load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      data_q <= '0;
      par_q  <= 1'b0;
    end else if (gen_accept) begin
      slot_q <= SLOT_FULL;
      data_q <= gen_data;
      par_q  <= gen_par;
    end else if (out_ready) begin
      slot_q <= SLOT_EMPTY;
    end
  end

  assign out_valid = (slot_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_par   = par_q;

  // Checker path

  assign chk_fail = (^chk_data) ^ chk_par ^ odd;

  // Clear is applied before counting, so a word arriving with clr is the first one counted.
  always_comb begin
    chk_err_d  = chk_valid && chk_fail;
    sticky_d   = clr ? 1'b0 : sticky_q;
    err_cnt_d  = clr ? '0   : err_cnt_q;
    word_cnt_d = clr ? '0   : word_cnt_q;
    if (chk_valid) begin
      word_cnt_d = sat_inc(word_cnt_d);
      if (chk_fail) begin
        err_cnt_d = sat_inc(err_cnt_d);
        sticky_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q  <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      chk_err_q  <= chk_err_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign chk_err    = chk_err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = err_cnt_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Self-checking bench for parity_gen_chk: directed cases plus randomized traffic
// compared against a parity/counter reference model.
module tb_parity_gen_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       odd = 1'b0;
  logic       gen_valid = 1'b0;
  logic [3:0] gen_data = '0;
  logic       out_ready = 1'b0;
  logic       chk_valid = 1'b0;
  logic [3:0] chk_data = '0;
  logic       chk_par = 1'b0;
  logic       clr = 1'b0;

  logic       gen_ready, out_valid, out_par, chk_err, err_sticky;
  logic [3:0] out_data;
  logic [7:0] err_cnt, word_cnt;

  logic       s_gen_ready, s_out_valid, s_out_par, s_chk_err, s_err_sticky;
  logic [3:0] s_out_data;
  logic [1:0] s_err_cnt, s_word_cnt;

  parity_gen_chk #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .odd(odd),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_data(gen_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_par(out_par),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_par(chk_par), .clr(clr),
    .chk_err(chk_err), .err_sticky(err_sticky), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  parity_gen_chk #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .odd(odd),
    .gen_valid(gen_valid), .gen_ready(s_gen_ready), .gen_data(gen_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_par(s_out_par),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_par(chk_par), .clr(clr),
    .chk_err(s_chk_err), .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  bit       m_valid, m_par, m_err, m_sticky, m_s_sticky;
  bit [3:0] m_data;
  int       m_ecnt, m_wcnt, m_s_ecnt, m_s_wcnt;

  function automatic bit parity_of(bit [3:0] d, bit o);
    return (($countones(d) % 2) == 1) ^ o;
  endfunction

  function automatic int sat_add(int v, int maxv);
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_valid = 0; m_par = 0; m_data = '0; m_err = 0;
    m_sticky = 0; m_ecnt = 0; m_wcnt = 0;
    m_s_sticky = 0; m_s_ecnt = 0; m_s_wcnt = 0;
  endtask

  task automatic check_all();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("out_data", out_data, m_data);
    check_eq("out_par", out_par, m_par);
    check_eq("chk_err", chk_err, m_err);
    check_eq("err_sticky", err_sticky, m_sticky);
    check_eq("err_cnt", err_cnt, m_ecnt);
    check_eq("word_cnt", word_cnt, m_wcnt);
    check_eq("sat_err_sticky", s_err_sticky, m_s_sticky);
    check_eq("sat_err_cnt", s_err_cnt, m_s_ecnt);
    check_eq("sat_word_cnt", s_word_cnt, m_s_wcnt);
  endtask

  // Inputs are set by the caller; the model advances on the same edge as the DUT.
  task automatic cycle();
    bit bad;
    #1;
    check_eq("gen_ready", gen_ready, !m_valid || out_ready);
    @(posedge clk);
    if (gen_valid && (!m_valid || out_ready)) begin
      m_valid = 1; m_data = gen_data; m_par = parity_of(gen_data, odd);
    end else if (out_ready) begin
      m_valid = 0;
    end
    bad = chk_valid && (parity_of(chk_data, odd) != chk_par);
    m_err = bad;
    if (clr) begin
      m_sticky = 0; m_ecnt = 0; m_wcnt = 0;
      m_s_sticky = 0; m_s_ecnt = 0; m_s_wcnt = 0;
    end
    if (chk_valid) begin
      m_wcnt = sat_add(m_wcnt, 255);
      m_s_wcnt = sat_add(m_s_wcnt, 3);
      if (bad) begin
        m_ecnt = sat_add(m_ecnt, 255); m_sticky = 1;
        m_s_ecnt = sat_add(m_s_ecnt, 3); m_s_sticky = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    gen_valid = 0; chk_valid = 0; clr = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    check_eq("rst_gen_ready", gen_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Build up out_valid=1 held and err_cnt=5, then reset asynchronously mid-cycle.
    out_ready = 0; gen_valid = 1; gen_data = 4'b1001; odd = 0;
    chk_valid = 1; chk_data = 4'b0001; chk_par = 0;
    cycle();
    gen_valid = 0;
    repeat (4) cycle();
    check_eq("pre_rst_err_cnt", err_cnt, 5);
    check_eq("pre_rst_out_valid", out_valid, 1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_mid_gen_ready", gen_ready, 1);
    check_eq("rst_mid_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Generator, full throughput.
    out_ready = 1; gen_valid = 1; gen_data = 4'b1011; odd = 0;
    cycle();
    check_eq("par_1011_even", out_par, 1);
    odd = 1;
    cycle();
    check_eq("par_1011_odd", out_par, 0);
    gen_data = 4'b0000; odd = 0;
    cycle();
    check_eq("par_0000_even", out_par, 0);
    check_eq("b2b_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      gen_data = 4'(i * 5 + 1); odd = 1'(i);
      cycle();
    end

    // Back-pressure.
    gen_data = 4'b0110; odd = 0;
    cycle();
    out_ready = 0; gen_data = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_data", out_data, 4'b0110);
      check_eq("bp_par", out_par, 0);
      check_eq("bp_ready", gen_ready, 0);
    end
    out_ready = 1;
    cycle();
    check_eq("bp_reload_data", out_data, 4'b1111);
    check_eq("bp_reload_valid", out_valid, 1);
    gen_valid = 0;
    cycle();
    check_eq("drain_valid", out_valid, 0);

    // Checker.
    clr = 1;
    cycle();
    clr = 0; odd = 0;
    chk_valid = 1; chk_data = 4'b1011; chk_par = 1;
    cycle();
    check_eq("chk_good", chk_err, 0);
    chk_par = 0;
    cycle();
    check_eq("chk_bad", chk_err, 1);
    check_eq("chk_err_cnt", err_cnt, 1);
    check_eq("chk_word_cnt", word_cnt, 2);
    check_eq("chk_sticky", err_sticky, 1);
    chk_valid = 0;
    cycle();
    check_eq("chk_pulse_end", chk_err, 0);

    // Saturation on the CNT_W=2 instance.
    chk_valid = 1; chk_data = 4'b0111; chk_par = 0;
    repeat (5) cycle();
    check_eq("sat_err", s_err_cnt, 3);
    check_eq("sat_word", s_word_cnt, 3);
    check_eq("nosat_err", err_cnt, 6);

    // Clear together with a bad word, then clear alone.
    clr = 1;
    cycle();
    check_eq("clr_bad_err", err_cnt, 1);
    check_eq("clr_bad_word", word_cnt, 1);
    check_eq("clr_bad_sticky", err_sticky, 1);
    chk_valid = 0;
    cycle();
    check_eq("clr_err", err_cnt, 0);
    check_eq("clr_word", word_cnt, 0);
    check_eq("clr_sticky", err_sticky, 0);
    clr = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      gen_valid = ($urandom % 4) != 0;
      gen_data  = 4'($urandom);
      out_ready = ($urandom % 3) != 0;
      odd       = 1'($urandom);
      chk_valid = 1'($urandom);
      chk_data  = 4'($urandom);
      chk_par   = 1'($urandom);
      clr       = ($urandom % 25) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_gen_chk.md
# parity_gen_chk

Registered, parametrised parity generator and checker with a valid/ready generator path and an always-accepting checker path. It generalises the four-input combinational parity generator to any data width, adds run-time even/odd selection, a one-stage pipelined generator output with back-pressure, and a checker with error pulse, sticky flag and saturating counters. It sits between a word producer and a serial/link stage, and at the receive side of the same link.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- CNT_W, 8, width of the error and word counters (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- odd  in  1  parity mode: 0 = even, 1 = odd; sampled per accepted word on both paths
- gen_valid  in  1  generator input word valid
- gen_ready  out  1  generator can accept a word this cycle
- gen_data  in  WIDTH  generator input word
- out_valid  out  1  out_data/out_par valid
- out_ready  in  1  downstream accepts out_data/out_par
- out_data  out  WIDTH  registered copy of accepted gen_data
- out_par  out  1  parity bit for out_data
- chk_valid  in  1  checker input valid (always accepted)
- chk_data  in  WIDTH  received word
- chk_par  in  1  received parity bit
- clr  in  1  synchronous clear of err_sticky, err_cnt, word_cnt
- chk_err  out  1  one-cycle pulse: previous checked word failed
- err_sticky  out  1  set on any failure, held until clr
- err_cnt  out  CNT_W  saturating count of failed words
- word_cnt  out  CNT_W  saturating count of checked words

## Operation
- Parity function: even mode par = XOR of all WIDTH data bits (total ones incl. par is even); odd mode par = inverse of that.
- Generator: single pipeline register. gen_ready = !out_valid || out_ready (combinational). Transfer in when gen_valid && gen_ready: load out_data = gen_data, out_par = f(gen_data, odd), out_valid = 1. If out_valid && out_ready and no new transfer, out_valid clears next cycle. Simultaneous drain and load: register reloads, out_valid stays 1 (full throughput, one word per cycle).
- While out_valid && !out_ready: out_data/out_par hold stable, gen_ready = 0.
- Checker: on chk_valid, err = XOR(chk_data) ^ chk_par ^ odd. Next cycle: chk_err = err (else 0); word_cnt += 1; if err, err_cnt += 1 and err_sticky = 1.
- Counters saturate at 2^CNT_W−1; no wrap.
- clr: next cycle err_sticky = 0, err_cnt = 0, word_cnt = 0. clr together with chk_valid: clear applied first, then the new word counted (word_cnt = 1, err_cnt = err, err_sticky = err). clr does not affect generator path or chk_err.
- odd may change any cycle; each word uses the value present at its acceptance.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_par = 0, chk_err = 0, err_sticky = 0, err_cnt = 0, word_cnt = 0. gen_ready = 1 during and after reset.
- Reset mid-transfer: held word discarded, no partial output; first word after release accepted on the first clk edge with rst_n high.
- Generator latency: 1 cycle from accepting edge to out_valid high.
- Checker latency: 1 cycle from chk_valid edge to chk_err / counter update.
- All outputs registered except gen_ready.

## Test plan
- Reset: assert rst_n = 0 mid-run with out_valid = 1 and err_cnt = 5 -> all outputs 0 immediately; gen_ready = 1.
- Generator, WIDTH = 4, out_ready = 1: gen_data 4'b1011 with odd = 0 -> out_par = 1; with odd = 1 -> out_par = 0; 4'b0000 even -> out_par = 0. Back-to-back words every cycle with out_valid held high.
- Back-pressure: out_ready = 0 for 3 cycles after loading 4'b0110 -> out_data/out_par stay 4'b0110/0, gen_ready = 0; out_ready = 1 with new gen_valid -> next word loads the same edge.
- Checker: chk_data 4'b1011, chk_par 1, odd 0 -> chk_err 0; chk_par 0 -> chk_err pulses 1 for one cycle; err_cnt = 1, word_cnt = 2, err_sticky = 1.
- Saturation, CNT_W = 2: 5 consecutive bad words -> err_cnt and word_cnt stop at 3.
- clr with a bad word in the same cycle -> err_cnt = 1, word_cnt = 1, err_sticky = 1; clr alone next -> all 0.
